// File: rtl/aes_128_stream_ctrl.sv
// Streaming front/back-end for a fixed-latency pipelined AES-128 core.
// Assembles key/plaintext from 32-bit words, issues 128-bit blocks, tracks
// in-flight blocks with a latency-matched valid pipe and buffers results in a
// credit-protected output FIFO.
module aes_128_stream_ctrl #(
  parameter int unsigned LATENCY    = 21,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_is_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         err_key_partial
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [1:0]         key_cnt;
  logic [1:0]         data_cnt;
  logic [127:0]       key_asm;
  logic [127:0]       key_reg;
  logic [127:0]       data_asm;
  logic [LATENCY-1:0] vpipe;
  logic [CNT_W-1:0]   inflight_cnt;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [127:0]       mem [FIFO_DEPTH];

  logic       accept;
  logic       key_acc;
  logic       data_acc;
  logic       credit;
  logic       issue;
  logic       push;
  logic       pop;
  logic [6:0] key_off;
  logic [6:0] data_off;

  assign accept   = in_valid & in_ready;
  assign key_acc  = accept & in_is_key;
  assign data_acc = accept & ~in_is_key;
  assign credit   = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue    = (state == ISSUE);
  assign push     = vpipe[LATENCY-1];
  assign pop      = out_valid & out_ready;
  // Slot 0 lands in [127:96]; (3 - cnt) equals ~cnt for a 2-bit counter.
  assign key_off  = {~key_cnt, 5'b0};
  assign data_off = {~data_cnt, 5'b0};

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign busy      = (state != COLLECT) | (data_cnt != 2'd0) |
                     (inflight_cnt != '0) | (fifo_cnt != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_n;
  end

  // Next-state logic: collect four data words, wait for credit, issue once.
  always_comb begin
    state_n = state;
    unique case (state)
      COLLECT: if (data_acc && data_cnt == 2'd3) state_n = WAIT;
      WAIT:    if (credit) state_n = ISSUE;
      ISSUE:   state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  // Input handshake, word assembly and the committed key register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      key_cnt  <= 2'd0;
      data_cnt <= 2'd0;
      key_asm  <= '0;
      key_reg  <= '0;
      data_asm <= '0;
    end else begin
      in_ready <= (state_n == COLLECT);
      if (key_acc) begin
        key_asm[key_off +: 32] <= in_data;
        key_cnt                <= key_cnt + 2'd1;
        if (key_cnt == 2'd3) key_reg <= {key_asm[127:32], in_data};
      end
      if (data_acc) begin
        data_asm[data_off +: 32] <= in_data;
        data_cnt                 <= data_cnt + 2'd1;
      end
    end
  end

  // Core inputs are loaded on entry to ISSUE and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_state      <= '0;
      core_key        <= '0;
      err_key_partial <= 1'b0;
    end else begin
      if (state == WAIT && credit) begin
        core_state <= data_asm;
        core_key   <= key_reg;
      end
      if (issue && key_cnt != 2'd0) err_key_partial <= 1'b1;
    end
  end

  // Latency-matched valid pipe and in-flight counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe        <= '0;
      inflight_cnt <= '0;
    end else begin
      vpipe <= {vpipe[LATENCY-2:0], issue};
      unique case ({issue, push})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // Output FIFO: tap pushes core_out, consumer pops the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= core_out;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credit accounting must make a push into a full FIFO without a pop impossible.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_cnt == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
// Directed bench for aes_128_stream_ctrl with a behavioural fixed-latency core.
module tb_aes_128_stream_ctrl;

  localparam int unsigned LAT = 21;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_is_key;
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         err_key_partial;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [127:0] core_pipe [LAT];
  logic [127:0] rx [$];

  aes_128_stream_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_is_key       (in_is_key),
    .core_state      (core_state),
    .core_key        (core_key),
    .core_out        (core_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy),
    .err_key_partial (err_key_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the AES core: exact answer for the FIPS-197 vector, otherwise a keyed mix.
  function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ {k[63:0], k[127:64]};
  endfunction

  // Core model: result for the inputs of cycle t appears on core_out in cycle t+LAT.
  always @(posedge clk) begin
    core_pipe[0] <= core_f(core_state, core_key);
    for (int i = 1; i < int'(LAT); i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  // Record every popped result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) rx.push_back(out_data);
  end

  function automatic logic [127:0] pt_of(input int i);
    logic [31:0] b;
    b = 32'h1000_0000 + 32'(i * 4);
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic k);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_is_key = k;
    while (!done && n < 300) begin
      @(negedge clk);
      done = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("handshake", 128'(done), 128'd1);
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int j = 0; j < 4; j++) send_word(k[127 - 32*j -: 32], 1'b1);
  endtask

  // Returns the cycle number right after the last data word was accepted.
  task automatic send_block(input logic [127:0] pt, output int p);
    for (int j = 0; j < 4; j++) send_word(pt[127 - 32*j -: 32], 1'b0);
    p = cyc;
  endtask

  task automatic wait_rx(input int count);
    int n;
    n = 0;
    while (rx.size() < count && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int p;
    int p3;
    int n;
    bit seen;
    logic [127:0] k3;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_is_key = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready",  128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data",  out_data, 128'd0);
    chk("rst_core_state", core_state, 128'd0);
    chk("rst_core_key",  core_key, 128'd0);
    chk("rst_busy",      128'(busy), 128'd0);
    chk("rst_err",       128'(err_key_partial), 128'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 vector with exact latency
    send_key(FIPS_KEY);
    send_block(FIPS_PT, p);
    chk("t1_busy", 128'(busy), 128'd1);
    wait_until(p + 1);
    chk("t1_core_state", core_state, FIPS_PT);
    chk("t1_core_key", core_key, FIPS_KEY);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t1_latency", 128'(cyc - p), 128'd23);
    chk("t1_out_data", out_data, FIPS_CT);
    tick();
    chk("t1_single_pulse", 128'(out_valid), 128'd0);
    repeat (3) tick();
    chk("t1_rx_count", 128'(rx.size()), 128'd1);
    chk("t1_idle", 128'(busy), 128'd0);

    // Back-pressure: only four blocks may be outstanding
    rx.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_block(pt_of(i), p);
    repeat (40) tick();
    chk("t2_in_ready_wait", 128'(in_ready), 128'd0);
    chk("t2_out_valid", 128'(out_valid), 128'd1);
    chk("t2_no_pop", 128'(rx.size()), 128'd0);
    chk("t2_head", out_data, core_f(pt_of(0), FIPS_KEY));
    chk("t2_fifth_not_issued", core_state, pt_of(3));
    out_ready = 1'b1;
    send_block(pt_of(5), p);
    wait_rx(6);
    chk("t2_rx_count", 128'(rx.size()), 128'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx.size()) chk($sformatf("t2_rx%0d", i), rx[i], core_f(pt_of(i), FIPS_KEY));
    end
    repeat (3) tick();
    chk("t2_idle", 128'(busy), 128'd0);

    // Tap push coinciding with a pop
    rx.delete();
    out_ready = 1'b0;
    for (int i = 10; i < 14; i++) send_block(pt_of(i), p3);
    wait_until(p3 + 22);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_one_pop", 128'(rx.size()), 128'd1);
    if (rx.size() > 0) chk("t3_first", rx[0], core_f(pt_of(10), FIPS_KEY));
    chk("t3_out_valid", 128'(out_valid), 128'd1);
    chk("t3_head", out_data, core_f(pt_of(11), FIPS_KEY));
    repeat (2) tick();
    chk("t3_held", 128'(rx.size()), 128'd1);
    out_ready = 1'b1;
    wait_rx(4);
    chk("t3_rx_count", 128'(rx.size()), 128'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < rx.size()) chk($sformatf("t3_rx%0d", i), rx[i], core_f(pt_of(10 + i), FIPS_KEY));
    end
    repeat (3) tick();
    chk("t3_no_extra", 128'(rx.size()), 128'd4);

    // New key interleaved within a data group
    rx.delete();
    send_word(pt_of(20)[127:96], 1'b0);
    send_word(pt_of(20)[95:64], 1'b0);
    send_key(KEY2);
    send_word(pt_of(20)[63:32], 1'b0);
    send_word(pt_of(20)[31:0], 1'b0);
    p = cyc;
    wait_until(p + 1);
    chk("t4_core_state", core_state, pt_of(20));
    chk("t4_core_key", core_key, KEY2);
    wait_rx(1);
    if (rx.size() > 0) chk("t4_result", rx[0], core_f(pt_of(20), KEY2));
    chk("t4_err", 128'(err_key_partial), 128'd0);

    // Partial key: issue keeps the last complete key and flags the error
    rx.delete();
    send_word(32'hdeadbeef, 1'b1);
    send_word(32'hcafef00d, 1'b1);
    send_block(pt_of(21), p);
    chk("t5_err_before", 128'(err_key_partial), 128'd0);
    wait_until(p + 1);
    chk("t5_core_key", core_key, KEY2);
    tick();
    chk("t5_err_set", 128'(err_key_partial), 128'd1);
    wait_rx(1);
    if (rx.size() > 0) chk("t5_result", rx[0], core_f(pt_of(21), KEY2));
    send_word(32'h01234567, 1'b1);
    send_word(32'h89abcdef, 1'b1);
    k3 = 128'hdeadbeefcafef00d0123456789abcdef;
    send_block(pt_of(22), p);
    wait_until(p + 1);
    chk("t5_completed_key", core_key, k3);
    wait_rx(2);
    if (rx.size() > 1) chk("t5_result2", rx[1], core_f(pt_of(22), k3));
    chk("t5_err_sticky", 128'(err_key_partial), 128'd1);

    // Reset ten cycles after an issue discards the block
    rx.delete();
    send_block(pt_of(30), p);
    wait_until(p + 11);
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 128'(out_valid), 128'd0);
    chk("t6_rst_busy", 128'(busy), 128'd0);
    chk("t6_rst_in_ready", 128'(in_ready), 128'd0);
    chk("t6_rst_err", 128'(err_key_partial), 128'd0);
    chk("t6_rst_core_state", core_state, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_in_ready", 128'(in_ready), 128'd1);
    chk("t6_busy", 128'(busy), 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("t6_no_output", 128'(seen), 128'd0);
    chk("t6_rx_empty", 128'(rx.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
